// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// KEYMAP is indexed [row][col] with row = ROW bit index, col = COL bit index.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Rows from r3 down to r0, each row packed c3..c0.
    localparam logic [3:0][3:0][3:0] KEYMAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] col_rotate(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick.sv
// Free-running 0..DIVISOR-1 counter; tick is high on the last count of every period.
module scan_tick #(
    parameter int DIVISOR = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [W-1:0] LAST = W'(DIVISOR - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad one column at a time, debounces presses and releases,
// and shifts each accepted key into a four-digit hex register.
//
// state    | meaning
// SCAN     | rotating columns, looking for exactly one low row
// DEBOUNCE | column held, counting identical samples of the candidate key
// PRESSED  | key accepted and held, waiting for an idle sample
// RELEASE  | counting idle samples before returning to SCAN
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [3:0]  ROW,
    output logic [3:0]  COL,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digits
);
    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int CW    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic [1:0] rst_pipe;
    logic       rst_n;
    logic [3:0] row_meta, row_sync;
    logic       tick;

    kp_state_t   state, state_n;
    logic [3:0]  col, col_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]  row_q, row_q_n, col_q, col_q_n;
    logic [3:0]  key_code_n;
    logic        key_valid_n, key_held_n;
    logic [15:0] digits_n;
    logic        sample_valid;
    logic [1:0]  sample_row, cur_col;

    // Assert asynchronously, release only after two clean clock edges.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN)
            rst_pipe <= 2'b00;
        else
            rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= ROW;
            row_sync <= row_meta;
        end
    end

    scan_tick #(.DIVISOR(DWELL)) u_tick (
        .clk   (CLK100MHZ),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Multiple low rows are a ghost pattern and treated the same as idle.
    always_comb begin
        sample_valid = 1'b0;
        sample_row   = 2'd0;
        case (row_sync)
            4'b1110: begin sample_valid = 1'b1; sample_row = 2'd0; end
            4'b1101: begin sample_valid = 1'b1; sample_row = 2'd1; end
            4'b1011: begin sample_valid = 1'b1; sample_row = 2'd2; end
            4'b0111: begin sample_valid = 1'b1; sample_row = 2'd3; end
            default: ;
        endcase
        cur_col = 2'd0;
        case (col)
            4'b1101: cur_col = 2'd1;
            4'b1011: cur_col = 2'd2;
            4'b0111: cur_col = 2'd3;
            default: cur_col = 2'd0;
        endcase
    end

    always_comb begin
        state_n     = state;
        col_n       = col;
        cnt_n       = cnt;
        row_q_n     = row_q;
        col_q_n     = col_q;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_held_n  = key_held;
        digits_n    = digits;
        case (state)
            SCAN: if (tick) begin
                if (sample_valid) begin
                    row_q_n = sample_row;
                    col_q_n = cur_col;
                    cnt_n   = CW'(1);
                    state_n = DEBOUNCE;
                end else begin
                    col_n = col_rotate(col);
                end
            end
            DEBOUNCE: if (tick) begin
                if (sample_valid && sample_row == row_q) begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state_n     = PRESSED;
                        key_valid_n = 1'b1;
                        key_held_n  = 1'b1;
                        key_code_n  = KEYMAP[row_q][col_q];
                        digits_n    = {digits[11:0], KEYMAP[row_q][col_q]};
                    end
                end else begin
                    cnt_n   = '0;
                    col_n   = col_rotate(col);
                    state_n = SCAN;
                end
            end
            PRESSED: if (tick && !sample_valid) begin
                cnt_n   = CW'(1);
                state_n = RELEASE;
            end
            RELEASE: if (tick) begin
                if (!sample_valid) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n      = '0;
                        key_held_n = 1'b0;
                        col_n      = col_rotate(col);
                        state_n    = SCAN;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end else begin
                    // Bounce back to a closed contact: no new key event.
                    cnt_n   = '0;
                    state_n = PRESSED;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col       <= 4'b1110;
            cnt       <= '0;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            digits    <= 16'h0000;
        end else begin
            state     <= state_n;
            col       <= col_n;
            cnt       <= cnt_n;
            row_q     <= row_q_n;
            col_q     <= col_q_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
            digits    <= digits_n;
        end
    end

    assign COL = col;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad matrix model.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_held;
    logic [15:0] digits;
    logic [15:0] pressed;   // bit r*4+c closes row r to column c

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    logic [3:0] last_code = 4'h0;

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            row[r] = ~|(pressed[r*4 +: 4] & ~col);
    end

    keypad_scanner #(.CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_SCANS(4)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .ROW        (row),
        .COL        (col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held),
        .digits     (digits)
    );

    always @(posedge clk) begin
        if (key_valid) begin
            vcnt      <= vcnt + 1;
            last_code <= key_code;
        end
    end

    task automatic wait_valid(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (vcnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_release(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        total++; if (col !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b want=1110", col); end
        total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code got=%h want=0", key_code); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", key_valid); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b want=0", key_held); end
        total++; if (digits !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h want=0000", digits); end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [3:0] prev, want;
        int n;
        bit seen;
        prev = col;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            seen = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                n++;
                if (col !== prev) begin seen = 1'b1; break; end
            end
            want = {prev[2:0], prev[3]};
            total++; if (!seen || col !== want) begin bad++; $display("FAIL scan_col step=%0d got=%b want=%b", k, col, want); end
            if (k > 0) begin
                total++; if (n != 10) begin bad++; $display("FAIL scan_dwell step=%0d got=%0d want=10", k, n); end
            end
            prev = col;
        end
        total++; if (vcnt != 0) begin bad++; $display("FAIL scan_no_valid got=%0d want=0", vcnt); end
        total++; if (digits !== 16'h0000) begin bad++; $display("FAIL scan_digits got=%h want=0000", digits); end
    endtask

    task automatic test_single_key();
        int base;
        bit ok;
        base = vcnt;
        pressed = 16'h0;
        pressed[1*4+2] = 1'b1;
        wait_valid(base + 1, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL key6_timeout got=%0d want=%0d", vcnt, base + 1); end
        total++; if (last_code !== 4'h6) begin bad++; $display("FAIL key6_code got=%h want=6", last_code); end
        total++; if (digits !== 16'h0006) begin bad++; $display("FAIL key6_digits got=%h want=0006", digits); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL key6_held got=%b want=1", key_held); end
        repeat (50) @(negedge clk);
        total++; if (col !== 4'b1011) begin bad++; $display("FAIL key6_col_frozen got=%b want=1011", col); end
        total++; if (vcnt != base + 1) begin bad++; $display("FAIL key6_once got=%0d want=%0d", vcnt, base + 1); end
        pressed = 16'h0;
        wait_release(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL key6_release got=%b want=0", key_held); end
        total++; if (vcnt != base + 1) begin bad++; $display("FAIL key6_after_release got=%0d want=%0d", vcnt, base + 1); end
    endtask

    task automatic test_sequence();
        int kr[5] = '{0, 0, 0, 0, 3};
        int kc[5] = '{0, 1, 2, 3, 0};
        logic [3:0] kcode[5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h0};
        int base;
        bit ok;
        base = vcnt;
        for (int k = 0; k < 5; k++) begin
            pressed = 16'h0;
            pressed[kr[k]*4 + kc[k]] = 1'b1;
            wait_valid(base + k + 1, 200, ok);
            total++; if (!ok || last_code !== kcode[k]) begin bad++; $display("FAIL seq_code idx=%0d got=%h want=%h", k, last_code, kcode[k]); end
            pressed = 16'h0;
            wait_release(200, ok);
            total++; if (!ok) begin bad++; $display("FAIL seq_release idx=%0d got=%b want=0", k, key_held); end
        end
        total++; if (digits !== 16'h23A0) begin bad++; $display("FAIL seq_digits got=%h want=23a0", digits); end
        total++; if (vcnt != base + 5) begin bad++; $display("FAIL seq_count got=%0d want=%0d", vcnt - base, 5); end
    endtask

    task automatic test_bounce();
        int base;
        bit ok;
        base = vcnt;
        pressed = 16'h0;
        for (int i = 0; i < 9; i++) begin
            pressed[0] = ~pressed[0];
            repeat (7) @(negedge clk);
        end
        total++; if (vcnt != base) begin bad++; $display("FAIL bounce_quiet got=%0d want=%0d", vcnt, base); end
        pressed = 16'h0;
        pressed[0] = 1'b1;
        wait_valid(base + 1, 200, ok);
        total++; if (!ok || last_code !== 4'h1) begin bad++; $display("FAIL bounce_code got=%h want=1", last_code); end
        repeat (100) @(negedge clk);
        total++; if (vcnt != base + 1) begin bad++; $display("FAIL bounce_once got=%0d want=%0d", vcnt, base + 1); end
        total++; if (digits !== 16'h3A01) begin bad++; $display("FAIL bounce_digits got=%h want=3a01", digits); end
        pressed = 16'h0;
        wait_release(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL bounce_release got=%b want=0", key_held); end
    endtask

    task automatic test_ghost();
        int base, changes;
        logic [3:0] prev;
        base = vcnt;
        changes = 0;
        pressed = 16'h0;
        pressed[0*4+1] = 1'b1;
        pressed[2*4+1] = 1'b1;
        prev = col;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (col !== prev) changes++;
            prev = col;
        end
        total++; if (changes < 14) begin bad++; $display("FAIL ghost_scanning got=%0d want>=14", changes); end
        total++; if (vcnt != base) begin bad++; $display("FAIL ghost_no_valid got=%0d want=%0d", vcnt, base); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL ghost_held got=%b want=0", key_held); end
        pressed = 16'h0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid_press();
        int base;
        bit ok;
        base = vcnt;
        pressed = 16'h0;
        pressed[2*4+2] = 1'b1;
        wait_valid(base + 1, 200, ok);
        total++; if (!ok || last_code !== 4'h9) begin bad++; $display("FAIL rst9_first got=%h want=9", last_code); end
        total++; if (digits !== 16'hA019) begin bad++; $display("FAIL rst9_digits_pre got=%h want=a019", digits); end
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (col !== 4'b1110) begin bad++; $display("FAIL rst9_col got=%b want=1110", col); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rst9_held got=%b want=0", key_held); end
        total++; if (digits !== 16'h0000) begin bad++; $display("FAIL rst9_digits got=%h want=0000", digits); end
        total++; if (key_code !== 4'h0) begin bad++; $display("FAIL rst9_code got=%h want=0", key_code); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(base + 2, 200, ok);
        total++; if (!ok || last_code !== 4'h9) begin bad++; $display("FAIL rst9_redetect got=%h want=9", last_code); end
        total++; if (digits !== 16'h0009) begin bad++; $display("FAIL rst9_digits_post got=%h want=0009", digits); end
        repeat (60) @(negedge clk);
        total++; if (vcnt != base + 2) begin bad++; $display("FAIL rst9_once got=%0d want=%0d", vcnt, base + 2); end
        pressed = 16'h0;
        wait_release(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst9_release got=%b want=0", key_held); end
    endtask

    initial begin
        rst_n   = 1'b0;
        pressed = 16'h0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_single_key();
        test_sequence();
        test_bounce();
        test_ghost();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
